// File: rtl/cmos_cgate_pipe.sv
// cmos_cgate_pipe: two-stage valid/ready pipeline around a WIDTH-bit six-input complex gate
// with four function modes and a saturating output-toggle counter.
module cmos_cgate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt
);
  localparam int PC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = (CNT_W > PC_W ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic             s1_valid, s2_load, accept, hs;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c, s1_d, s1_e, s1_f;
  logic [WIDTH-1:0] pos, y_next, y_last;
  logic [PC_W-1:0]  delta;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;
  assign s2_load  = s1_valid & (!out_valid | out_ready);
  assign in_ready = !s1_valid | s2_load;
  assign accept   = in_valid & in_ready;
  assign hs       = out_valid & out_ready;
  always_comb begin
    pos    = (s1_a | s1_b) & ((s1_c & s1_d) | (s1_e & s1_f));
    y_next = s1_mode == 2'b00 ? ~pos :
             s1_mode == 2'b01 ? pos :
             s1_mode == 2'b10 ? ~((s1_a & s1_b) | ((s1_c | s1_d) & (s1_e | s1_f))) : s1_a;
    delta = '0;
    for (int i = 0; i < WIDTH; i++) delta = delta + PC_W'(y[i] ^ y_last[i]);
    // a clear coinciding with a transfer restarts the count from this transfer's delta
    sum      = SUM_W'(cnt_clr ? '0 : toggle_cnt) + SUM_W'(delta);
    cnt_next = sum > SUM_W'(CNT_MAX) ? CNT_MAX : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_mode    <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_c       <= '0;
      s1_d       <= '0;
      s1_e       <= '0;
      s1_f       <= '0;
      out_valid  <= 1'b0;
      y          <= '0;
      y_last     <= '0;
      toggle_cnt <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_mode  <= mode;
        s1_a     <= a;
        s1_b     <= b;
        s1_c     <= c;
        s1_d     <= d;
        s1_e     <= e;
        s1_f     <= f;
      end else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) begin
        y         <= y_next;
        out_valid <= 1'b1;
      end else if (hs) out_valid <= 1'b0;
      if (hs) begin
        y_last     <= y;
        toggle_cnt <= cnt_next;
      end else if (cnt_clr) toggle_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_cmos_cgate_pipe.sv
// tb_cmos_cgate_pipe: directed scoreboard bench for cmos_cgate_pipe, with a CNT_W=4 twin
// sharing all inputs to exercise counter saturation.
module tb_cmos_cgate_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cnt_clr;
  logic [1:0]  mode;
  logic [7:0]  a, b, c, d, e, f, y, y4;
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [15:0] toggle_cnt;
  logic [3:0]  cnt4;
  logic [7:0]  exp_q[$], got_q[$];
  logic [7:0]  m_last, ex, y_hold, first_exp;
  int          tests = 0, fails = 0, m_cnt = 0, m4 = 0, w, dl;

  cmos_cgate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt));

  cmos_cgate_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .mode(mode),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .cnt_clr(cnt_clr), .toggle_cnt(cnt4));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] fn(input logic [1:0] m, input logic [7:0] pa, pb, pc, pd, pe, pf);
    case (m)
      2'b00:   return ~((pa | pb) & ((pc & pd) | (pe & pf)));
      2'b01:   return (pa | pb) & ((pc & pd) | (pe & pf));
      2'b10:   return ~((pa & pb) | ((pc | pd) & (pe | pf)));
      default: return pa;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] va, vb, vc, vd, ve, vf, output int wt);
    mode = m; a = va; b = vb; c = vc; d = vd; e = ve; f = vf;
    in_valid = 1'b1;
    wt = 0;
    @(negedge clk);
    while (!in_ready && wt < 50) begin
      wt++;
      @(negedge clk);
    end
    check("accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: push model result on accept, pop and compare on each output handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      got_q.delete();
      m_cnt = 0;
      m4 = 0;
      m_last = '0;
    end else begin
      check("cnt16", toggle_cnt, 32'(m_cnt));
      check("cnt4", cnt4, 32'(m4));
      if (out_valid && out_ready) begin
        check("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ex = exp_q.pop_front();
          check("y", y, ex);
          check("y4", y4, ex);
        end
        got_q.push_back(y);
        dl = $countones(y ^ m_last);
        m_last = y;
        m_cnt = (cnt_clr ? 0 : m_cnt) + dl;
        m4 = (cnt_clr ? 0 : m4) + dl;
        if (m_cnt > 65535) m_cnt = 65535;
        if (m4 > 15) m4 = 15;
      end else if (cnt_clr) begin
        m_cnt = 0;
        m4 = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(fn(mode, a, b, c, d, e, f));
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    mode = '0; a = '0; b = '0; c = '0; d = '0; e = '0; f = '0;
    tick(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_cnt", toggle_cnt, 0);
    rst_n = 1'b1;
    tick(1);
    // T1: all-ones base gate, latency
    send(2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, w);
    check("t1_lat0", out_valid, 0);
    tick(1);
    check("t1_lat1", out_valid, 1);
    check("t1_y", y, 8'h00);
    tick(1);
    check("t1_cnt", toggle_cnt, 0);
    // T2: the four modes on one operand set
    for (int m = 0; m < 4; m++) send(2'(m), 8'hF0, 8'h0C, 8'hAA, 8'hFF, 8'h55, 8'h0F, w);
    tick(4);
    check("t2_n", got_q.size(), 5);
    check("t2_m0", got_q[1], 8'h53);
    check("t2_m1", got_q[2], 8'hAC);
    check("t2_m2", got_q[3], 8'hA0);
    check("t2_m3", got_q[4], 8'hF0);
    // T3: 16 back-to-back random beats
    for (int i = 0; i < 16; i++) begin
      logic [7:0] r[6];
      logic [1:0] rm;
      foreach (r[k]) r[k] = 8'($urandom);
      rm = 2'($urandom);
      if (i == 0) first_exp = fn(rm, r[0], r[1], r[2], r[3], r[4], r[5]);
      send(rm, r[0], r[1], r[2], r[3], r[4], r[5], w);
      check("t3_nowait", w, 0);
      if (i == 0) check("t3_lat0", out_valid, 0);
      if (i == 1) begin
        check("t3_lat1", out_valid, 1);
        check("t3_first", y, first_exp);
      end
    end
    tick(4);
    check("t3_n", got_q.size(), 21);
    check("t3_drained", exp_q.size(), 0);
    // T4: backpressure, two accepts then in_ready drops and y holds
    out_ready = 1'b0;
    send(2'b01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, w);
    send(2'b10, 8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, w);
    check("t4_in_ready", in_ready, 0);
    check("t4_out_valid", out_valid, 1);
    check("t4_y", y, fn(2'b01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC));
    y_hold = y;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t4_hold", y, y_hold);
      check("t4_blocked", in_ready, 0);
    end
    out_ready = 1'b1;
    tick(4);
    check("t4_n", got_q.size(), 23);
    check("t4_drained", exp_q.size(), 0);
    // T5: toggle counting and saturation
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    send(2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    tick(3);
    check("t5_c0", toggle_cnt, 0);
    send(2'b11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    tick(3);
    check("t5_c8", toggle_cnt, 8);
    send(2'b11, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    tick(3);
    check("t5_c12", toggle_cnt, 12);
    check("t5_c4_12", cnt4, 12);
    send(2'b11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    send(2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    send(2'b11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    tick(3);
    check("t5_c32", toggle_cnt, 32);
    check("t5_sat", cnt4, 15);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("t5_clr", toggle_cnt, 0);
    check("t5_clr4", cnt4, 0);
    send(2'b11, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, w);
    tick(1);
    check("t5_pend", out_valid, 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("t5_clr_hs", toggle_cnt, 4);
    check("t5_clr_hs4", cnt4, 4);
    // T6: async reset with both stages full and stalled
    out_ready = 1'b0;
    send(2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, w);
    send(2'b01, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, w);
    check("t6_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_y", y, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_cnt", toggle_cnt, 0);
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(2);
    check("t6_idle", out_valid, 0);
    send(2'b10, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, w);
    tick(3);
    check("t6_n", got_q.size(), 1);
    check("t6_new", got_q[0], fn(2'b10, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
